y86_regfile_pipe: RTL and testbench
===================================

// Module: y86_regfile_pipe
// PURPOSE
//  Parametrised Y86-64 register file with integrated decode-source/destination logic and D->E pipeline register.
//  Two write ports (E, M) from writeback, two read ports (A, B) with optional write-through bypass, and a debug read port.
//  Sits between fetch and execute in the pipelined core. Replaces the combined decode/writeback block used in the sequential core.
// PARAMETERS
//  DATA_W   64    register/data width
//  NREGS    15    architectural registers, indices 0..NREGS-1
//  ADDR_W   4     register index width; index 2**ADDR_W-1 (4'hF) = RNONE
//  RSP_IDX  4     stack-pointer index
//  SP_INIT  254   reset value of register RSP_IDX
//  BYPASS   1     1: same-cycle write data forwarded to reads; 0: reads see array only
// PORTS
//  clk        in   1       clock, all state on posedge
//  rst        in   1       synchronous, active-high reset
//  d_valid    in   1       decode-stage instruction valid
//  d_icode    in   4       decode icode
//  d_ifun     in   4       decode ifun (passed through)
//  d_rA,d_rB  in   ADDR_W  register specifiers from fetch
//  stall      in   1       hold D->E register
//  bubble     in   1       load NOP into D->E register
//  w_valid    in   1       writeback valid
//  w_dstE     in   ADDR_W  E-port destination (cmov condition already resolved upstream)
//  w_valE     in   DATA_W  E-port data
//  w_dstM     in   ADDR_W  M-port destination
//  w_valM     in   DATA_W  M-port data
//  e_valid    out  1       registered: execute-stage valid
//  e_icode    out  4       registered icode
//  e_ifun     out  4       registered ifun
//  e_valA     out  DATA_W  registered read-port A value
//  e_valB     out  DATA_W  registered read-port B value
//  e_srcA,e_srcB out ADDR_W registered source indices (for forwarding logic)
//  e_dstE,e_dstM out ADDR_W registered destination indices
//  e_ins_err  out  1       registered: d_valid with icode > 4'hB
//  dbg_addr   in   ADDR_W  debug read index
//  dbg_data   out  DATA_W  combinational array[dbg_addr]; 0 if >= NREGS
// BEHAVIOUR
//  Decode table (srcA,srcB,dstE,dstM; F=RNONE, SP=RSP_IDX):
//   0 halt,1 nop,7 jXX: F,F,F,F | 2 cmov: rA,F,rB,F | 3 irmov: F,F,rB,F | 4 rmmov: rA,rB,F,F
//   5 mrmov: F,rB,F,rA | 6 OPq: rA,rB,rB,F | 8 call: F,SP,SP,F | 9 ret: SP,SP,SP,F
//   A push: rA,SP,SP,F | B pop: SP,SP,SP,rA | C..F: F,F,F,F and ins_err=1
//  Read: index F or >= NREGS returns 0. Combinational from array, then into D->E register.
//  Bypass (BYPASS=1): read index equal to valid w_dstM returns w_valM; else equal to w_dstE returns w_valE; else array.
//  Write at posedge when w_valid: dstE (if != F and < NREGS) <= w_valE; dstM likewise <= w_valM.
//   Same index on both ports: M wins (popq %rsp loads memory value). Out-of-range/RNONE writes ignored, no error.
//  D->E register per cycle, priority rst > stall > bubble > load:
//   rst: array=0 except [RSP_IDX]=SP_INIT; e_valid=0, e_icode=1, e_ifun=0, e_valA=e_valB=0, e_src*/e_dst*=F, e_ins_err=0.
//   stall: all e_* hold. Writes still occur.
//   bubble: e_valid=0, e_icode=1 (nop), e_ifun=0, values 0, indices F, e_ins_err=0.
//   load: e_valid=d_valid; when d_valid=0 the fields take the bubble values.
//  Latency: decode-to-e_* one cycle. Write-to-array one cycle. With bypass, write-to-read is 0 cycles.
//  rst asserted with w_valid: reset wins, write is dropped.
//  dbg_data reads the array only, never the bypass path.
// TESTING
//  Reset: rst 1 cycle -> dbg r4=254, r0..r3,r5..r14=0; e_valid=0, e_icode=1, e_dstE=F.
//  Bypass: w_dstE=3,w_valE=77 and same cycle d_icode=6,rA=3,rB=0 -> next e_valA=77, e_valB=0, e_dstE=0. BYPASS=0 -> e_valA=0.
//  Pop conflict: w_dstE=4,w_valE=262,w_dstM=4,w_valM=9 -> dbg r4=9. dstE=4,dstM=2 -> r4=262, r2=9.
//  Stall/bubble: load push(rA=1). Stall 3 cycles -> e_* constant. Stall+bubble -> held. Bubble alone -> e_valid=0, e_icode=1.
//  Ignored writes: w_dstE=F or w_dstE=15 with valE=5 -> array unchanged. w_valid=0 with dstE=2 -> unchanged.
//  Invalid icode: d_valid=1, icode=4'hD -> e_ins_err=1, all indices F. Next cycle icode=9 -> e_srcA=e_srcB=e_dstE=4, e_valA=254.

Source files
------------

// File: rtl/y86_regfile_pipe_if.sv
// y86_regfile_pipe_if
//   Bundles every non-clock signal of the Y86-64 register file / D->E stage.
//   master: the surrounding pipeline (fetch/writeback/execute side).
//   slave : the register file block itself.
//
//   Valid semantics (no back-pressure on any path):
//     d_valid qualifies d_icode/d_ifun/d_rA/d_rB in the cycle it is high.
//     w_valid qualifies both writeback ports in the cycle it is high.
//     e_valid qualifies every e_* field one cycle after its decode cycle.
//     stall freezes the D->E register; it is the only flow-control input.
//
//   Signals:
//     d_valid, d_icode, d_ifun, d_rA, d_rB   decode-stage instruction
//     stall, bubble                          D->E register control
//     w_valid, w_dstE, w_valE, w_dstM, w_valM writeback ports
//     e_*                                    registered execute-stage fields
//     dbg_addr / dbg_data                    array-only debug read
interface y86_regfile_pipe_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4
);
    logic              d_valid;
    logic [3:0]        d_icode;
    logic [3:0]        d_ifun;
    logic [ADDR_W-1:0] d_rA;
    logic [ADDR_W-1:0] d_rB;
    logic              stall;
    logic              bubble;
    logic              w_valid;
    logic [ADDR_W-1:0] w_dstE;
    logic [DATA_W-1:0] w_valE;
    logic [ADDR_W-1:0] w_dstM;
    logic [DATA_W-1:0] w_valM;
    logic              e_valid;
    logic [3:0]        e_icode;
    logic [3:0]        e_ifun;
    logic [DATA_W-1:0] e_valA;
    logic [DATA_W-1:0] e_valB;
    logic [ADDR_W-1:0] e_srcA;
    logic [ADDR_W-1:0] e_srcB;
    logic [ADDR_W-1:0] e_dstE;
    logic [ADDR_W-1:0] e_dstM;
    logic              e_ins_err;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output d_valid, d_icode, d_ifun, d_rA, d_rB, stall, bubble,
        output w_valid, w_dstE, w_valE, w_dstM, w_valM, dbg_addr,
        input  e_valid, e_icode, e_ifun, e_valA, e_valB, e_srcA, e_srcB,
        input  e_dstE, e_dstM, e_ins_err, dbg_data
    );

    modport slave (
        input  d_valid, d_icode, d_ifun, d_rA, d_rB, stall, bubble,
        input  w_valid, w_dstE, w_valE, w_dstM, w_valM, dbg_addr,
        output e_valid, e_icode, e_ifun, e_valA, e_valB, e_srcA, e_srcB,
        output e_dstE, e_dstM, e_ins_err, dbg_data
    );
endinterface

// File: rtl/y86_regfile_pipe.sv
// y86_regfile_pipe
//   Y86-64 register file with decode source/destination selection and the
//   D->E pipeline register. Two writeback ports (E, M; M wins on equal index),
//   two read ports (A, B) with optional same-cycle write-through, and an
//   array-only debug read port.
//
//   Ports:
//     clk  clock, all state updates on posedge
//     rst  synchronous active-high reset (array cleared, RSP = SP_INIT,
//          D->E register loaded with a bubble)
//     bus  y86_regfile_pipe_if.slave: decode inputs, stall/bubble, writeback
//          ports, registered e_* outputs, dbg_addr/dbg_data
module y86_regfile_pipe #(
    parameter int DATA_W  = 64,
    parameter int NREGS   = 15,
    parameter int ADDR_W  = 4,
    parameter int RSP_IDX = 4,
    parameter int SP_INIT = 254,
    parameter int BYPASS  = 1
) (
    input  logic clk,
    input  logic rst,
    y86_regfile_pipe_if.slave bus
);
    localparam logic [ADDR_W-1:0] RNONE = '1;
    localparam logic [ADDR_W-1:0] RSP   = ADDR_W'(RSP_IDX);
    localparam logic [3:0]        I_NOP = 4'h1;

    logic [DATA_W-1:0] regs [NREGS];

    logic [ADDR_W-1:0] src_a, src_b, dst_e, dst_m;
    logic              ins_err;
    logic [DATA_W-1:0] val_a, val_b;

    // RNONE and indices beyond the array are treated as "no register".
    function automatic logic in_range(input logic [ADDR_W-1:0] idx);
        return (idx != RNONE) && (int'(idx) < NREGS);
    endfunction

    // Read port: M-port data beats E-port data so a pop into %rsp reads the
    // memory value, matching the write priority below.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] v;
        v = '0;
        if (in_range(idx)) begin
            if (BYPASS != 0 && bus.w_valid && bus.w_dstM == idx)
                v = bus.w_valM;
            else if (BYPASS != 0 && bus.w_valid && bus.w_dstE == idx)
                v = bus.w_valE;
            else
                v = regs[idx];
        end
        return v;
    endfunction

    // Decode table; an invalid decode slot selects no registers at all.
    always_comb begin
        src_a   = RNONE;
        src_b   = RNONE;
        dst_e   = RNONE;
        dst_m   = RNONE;
        ins_err = 1'b0;
        if (bus.d_valid) begin
            case (bus.d_icode)
                4'h2: begin src_a = bus.d_rA; dst_e = bus.d_rB; end
                4'h3: begin dst_e = bus.d_rB; end
                4'h4: begin src_a = bus.d_rA; src_b = bus.d_rB; end
                4'h5: begin src_b = bus.d_rB; dst_m = bus.d_rA; end
                4'h6: begin src_a = bus.d_rA; src_b = bus.d_rB; dst_e = bus.d_rB; end
                4'h8: begin src_b = RSP; dst_e = RSP; end
                4'h9: begin src_a = RSP; src_b = RSP; dst_e = RSP; end
                4'hA: begin src_a = bus.d_rA; src_b = RSP; dst_e = RSP; end
                4'hB: begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = bus.d_rA; end
                4'hC, 4'hD, 4'hE, 4'hF: ins_err = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        val_a = read_port(src_a);
        val_b = read_port(src_b);
    end

    // Register array. M is written after E so it wins on an equal index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                if (i == RSP_IDX) regs[i] <= DATA_W'(SP_INIT);
                else              regs[i] <= '0;
            end
        end else if (bus.w_valid) begin
            if (in_range(bus.w_dstE)) regs[bus.w_dstE] <= bus.w_valE;
            if (in_range(bus.w_dstM)) regs[bus.w_dstM] <= bus.w_valM;
        end
    end

    // D->E register: rst > stall > bubble > load. A load with d_valid=0
    // naturally produces bubble values because decode selected RNONE.
    always_ff @(posedge clk) begin
        if (rst || (!bus.stall && (bus.bubble || !bus.d_valid))) begin
            bus.e_valid   <= 1'b0;
            bus.e_icode   <= I_NOP;
            bus.e_ifun    <= 4'h0;
            bus.e_valA    <= '0;
            bus.e_valB    <= '0;
            bus.e_srcA    <= RNONE;
            bus.e_srcB    <= RNONE;
            bus.e_dstE    <= RNONE;
            bus.e_dstM    <= RNONE;
            bus.e_ins_err <= 1'b0;
        end else if (!bus.stall) begin
            bus.e_valid   <= 1'b1;
            bus.e_icode   <= bus.d_icode;
            bus.e_ifun    <= bus.d_ifun;
            bus.e_valA    <= val_a;
            bus.e_valB    <= val_b;
            bus.e_srcA    <= src_a;
            bus.e_srcB    <= src_b;
            bus.e_dstE    <= dst_e;
            bus.e_dstM    <= dst_m;
            bus.e_ins_err <= ins_err;
        end
    end

    assign bus.dbg_data = (int'(bus.dbg_addr) < NREGS) ? regs[bus.dbg_addr] : '0;
endmodule

// File: tb/tb_y86_regfile_pipe.sv
module tb_y86_regfile_pipe;
    localparam int DW = 64;
    localparam int AW = 4;
    localparam logic [AW-1:0] F = 4'hF;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    y86_regfile_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    y86_regfile_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus_nb ();

    // The no-bypass instance mirrors every input of the main one.
    assign bus_nb.d_valid  = bus.d_valid;
    assign bus_nb.d_icode  = bus.d_icode;
    assign bus_nb.d_ifun   = bus.d_ifun;
    assign bus_nb.d_rA     = bus.d_rA;
    assign bus_nb.d_rB     = bus.d_rB;
    assign bus_nb.stall    = bus.stall;
    assign bus_nb.bubble   = bus.bubble;
    assign bus_nb.w_valid  = bus.w_valid;
    assign bus_nb.w_dstE   = bus.w_dstE;
    assign bus_nb.w_valE   = bus.w_valE;
    assign bus_nb.w_dstM   = bus.w_dstM;
    assign bus_nb.w_valM   = bus.w_valM;
    assign bus_nb.dbg_addr = bus.dbg_addr;

    y86_regfile_pipe #(.BYPASS(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    y86_regfile_pipe #(.BYPASS(0)) dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [DW-1:0] exp_regs [15];

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_decode(input logic v, input logic [3:0] ic, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        bus.d_valid = v;
        bus.d_icode = ic;
        bus.d_ifun  = 4'h0;
        bus.d_rA    = ra;
        bus.d_rB    = rb;
    endtask

    task automatic set_write(input logic v, input logic [AW-1:0] de, input logic [DW-1:0] ve,
                             input logic [AW-1:0] dm, input logic [DW-1:0] vm);
        bus.w_valid = v;
        bus.w_dstE  = de;
        bus.w_valE  = ve;
        bus.w_dstM  = dm;
        bus.w_valM  = vm;
    endtask

    task automatic idle();
        set_decode(1'b0, 4'h1, F, F);
        set_write(1'b0, F, '0, F, '0);
        bus.stall    = 1'b0;
        bus.bubble   = 1'b0;
        bus.dbg_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_write(1'b1, 4'd2, 64'd33, F, '0);
        step();
        // reset together with a write: the write must be dropped
        rst = 1'b1;
        set_write(1'b1, 4'd2, 64'd5, 4'd3, 64'd6);
        step();
        rst = 1'b0;
        set_write(1'b0, F, '0, F, '0);
        for (int i = 0; i < 15; i++) exp_regs[i] = (i == 4) ? 64'd254 : 64'd0;
        for (int i = 0; i < 16; i++) begin
            bus.dbg_addr = AW'(i);
            #1;
            total_cnt++;
            if (bus.dbg_data !== ((i == 4) ? 64'd254 : 64'd0))
                $display("FAIL reset_dbg r%0d got %0d want %0d", i, bus.dbg_data, (i == 4) ? 254 : 0);
            else pass_cnt++;
        end
        total_cnt++; if (bus.e_valid !== 1'b0) $display("FAIL reset_e_valid got %0b want 0", bus.e_valid); else pass_cnt++;
        total_cnt++; if (bus.e_icode !== 4'h1) $display("FAIL reset_e_icode got %0h want 1", bus.e_icode); else pass_cnt++;
        total_cnt++; if (bus.e_dstE !== F) $display("FAIL reset_e_dstE got %0h want f", bus.e_dstE); else pass_cnt++;
        total_cnt++; if (bus.e_valA !== 64'd0) $display("FAIL reset_e_valA got %0d want 0", bus.e_valA); else pass_cnt++;
    endtask

    task automatic test_bypass();
        // OPq rA=3 rB=0 while r3 is written with 77 in the same cycle
        set_decode(1'b1, 4'h6, 4'd3, 4'd0);
        set_write(1'b1, 4'd3, 64'd77, F, '0);
        step();
        exp_regs[3] = 64'd77;
        total_cnt++; if (bus.e_valA !== 64'd77) $display("FAIL bypass_valA got %0d want 77", bus.e_valA); else pass_cnt++;
        total_cnt++; if (bus.e_valB !== 64'd0) $display("FAIL bypass_valB got %0d want 0", bus.e_valB); else pass_cnt++;
        total_cnt++; if (bus.e_dstE !== 4'd0) $display("FAIL bypass_dstE got %0h want 0", bus.e_dstE); else pass_cnt++;
        total_cnt++; if (bus.e_srcA !== 4'd3) $display("FAIL bypass_srcA got %0h want 3", bus.e_srcA); else pass_cnt++;
        total_cnt++; if (bus_nb.e_valA !== 64'd0) $display("FAIL nobypass_valA got %0d want 0", bus_nb.e_valA); else pass_cnt++;
        // both ports target r5: the M value is forwarded
        set_decode(1'b1, 4'h6, 4'd5, 4'd3);
        set_write(1'b1, 4'd5, 64'd22, 4'd5, 64'd11);
        step();
        exp_regs[5] = 64'd11;
        total_cnt++; if (bus.e_valA !== 64'd11) $display("FAIL bypass_m_wins got %0d want 11", bus.e_valA); else pass_cnt++;
        total_cnt++; if (bus.e_valB !== 64'd77) $display("FAIL bypass_array_valB got %0d want 77", bus.e_valB); else pass_cnt++;
        total_cnt++; if (bus_nb.e_valA !== 64'd0) $display("FAIL nobypass_valA2 got %0d want 0", bus_nb.e_valA); else pass_cnt++;
        total_cnt++; if (bus_nb.e_valB !== 64'd77) $display("FAIL nobypass_valB2 got %0d want 77", bus_nb.e_valB); else pass_cnt++;
        idle();
        step();
    endtask

    task automatic test_pop_conflict();
        set_write(1'b1, 4'd4, 64'd262, 4'd4, 64'd9);
        step();
        bus.dbg_addr = 4'd4; #1;
        total_cnt++; if (bus.dbg_data !== 64'd9) $display("FAIL pop_same_r4 got %0d want 9", bus.dbg_data); else pass_cnt++;
        set_write(1'b1, 4'd4, 64'd262, 4'd2, 64'd9);
        step();
        bus.dbg_addr = 4'd4; #1;
        total_cnt++; if (bus.dbg_data !== 64'd262) $display("FAIL pop_split_r4 got %0d want 262", bus.dbg_data); else pass_cnt++;
        bus.dbg_addr = 4'd2; #1;
        total_cnt++; if (bus.dbg_data !== 64'd9) $display("FAIL pop_split_r2 got %0d want 9", bus.dbg_data); else pass_cnt++;
        exp_regs[2] = 64'd9;
        set_write(1'b1, 4'd4, 64'd254, F, '0);
        step();
        set_write(1'b0, F, '0, F, '0);
    endtask

    task automatic test_stall_bubble();
        set_write(1'b1, 4'd1, 64'd1000, F, '0);
        step();
        set_write(1'b0, F, '0, F, '0);
        set_decode(1'b1, 4'hA, 4'd1, F);
        step();
        total_cnt++; if (bus.e_icode !== 4'hA) $display("FAIL push_icode got %0h want a", bus.e_icode); else pass_cnt++;
        total_cnt++; if (bus.e_valA !== 64'd1000) $display("FAIL push_valA got %0d want 1000", bus.e_valA); else pass_cnt++;
        total_cnt++; if (bus.e_valB !== 64'd254) $display("FAIL push_valB got %0d want 254", bus.e_valB); else pass_cnt++;
        total_cnt++; if (bus.e_srcB !== 4'd4 || bus.e_dstE !== 4'd4 || bus.e_dstM !== F)
            $display("FAIL push_idx got srcB=%0h dstE=%0h dstM=%0h want 4 4 f", bus.e_srcB, bus.e_dstE, bus.e_dstM);
        else pass_cnt++;
        // stall with a different instruction waiting and a write still landing
        bus.stall = 1'b1;
        set_decode(1'b1, 4'h6, 4'd2, 4'd3);
        set_write(1'b1, 4'd1, 64'd555, F, '0);
        exp_regs[1] = 64'd555;
        for (int c = 0; c < 3; c++) begin
            step();
            set_write(1'b0, F, '0, F, '0);
            total_cnt++;
            if (bus.e_valid !== 1'b1 || bus.e_icode !== 4'hA || bus.e_valA !== 64'd1000 || bus.e_srcA !== 4'd1 || bus.e_dstE !== 4'd4)
                $display("FAIL stall_hold c%0d got v=%0b ic=%0h valA=%0d srcA=%0h want 1 a 1000 1", c, bus.e_valid, bus.e_icode, bus.e_valA, bus.e_srcA);
            else pass_cnt++;
        end
        bus.dbg_addr = 4'd1; #1;
        total_cnt++; if (bus.dbg_data !== 64'd555) $display("FAIL stall_write_r1 got %0d want 555", bus.dbg_data); else pass_cnt++;
        bus.bubble = 1'b1;
        step();
        total_cnt++; if (bus.e_valid !== 1'b1 || bus.e_icode !== 4'hA)
            $display("FAIL stall_bubble_hold got v=%0b ic=%0h want 1 a", bus.e_valid, bus.e_icode);
        else pass_cnt++;
        bus.stall = 1'b0;
        step();
        total_cnt++; if (bus.e_valid !== 1'b0 || bus.e_icode !== 4'h1 || bus.e_srcA !== F || bus.e_valA !== 64'd0 || bus.e_dstE !== F)
            $display("FAIL bubble got v=%0b ic=%0h srcA=%0h valA=%0d dstE=%0h want 0 1 f 0 f", bus.e_valid, bus.e_icode, bus.e_srcA, bus.e_valA, bus.e_dstE);
        else pass_cnt++;
        bus.bubble = 1'b0;
        set_decode(1'b0, 4'h6, 4'd2, 4'd3);
        step();
        total_cnt++; if (bus.e_valid !== 1'b0 || bus.e_icode !== 4'h1 || bus.e_srcB !== F || bus.e_valB !== 64'd0)
            $display("FAIL invalid_load got v=%0b ic=%0h srcB=%0h valB=%0d want 0 1 f 0", bus.e_valid, bus.e_icode, bus.e_srcB, bus.e_valB);
        else pass_cnt++;
    endtask

    task automatic test_ignored_writes();
        set_write(1'b1, F, 64'd5, F, 64'd5);
        step();
        set_write(1'b1, 4'd15, 64'd5, 4'd15, 64'd5);
        step();
        set_write(1'b0, 4'd2, 64'd5, 4'd2, 64'd5);
        step();
        set_write(1'b0, F, '0, F, '0);
        for (int i = 0; i < 15; i++) begin
            bus.dbg_addr = AW'(i);
            #1;
            total_cnt++;
            if (bus.dbg_data !== exp_regs[i])
                $display("FAIL ignored_r%0d got %0d want %0d", i, bus.dbg_data, exp_regs[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_invalid_icode();
        set_decode(1'b1, 4'hD, 4'd1, 4'd2);
        step();
        total_cnt++; if (bus.e_ins_err !== 1'b1 || bus.e_valid !== 1'b1 || bus.e_icode !== 4'hD)
            $display("FAIL ins_err got err=%0b v=%0b ic=%0h want 1 1 d", bus.e_ins_err, bus.e_valid, bus.e_icode);
        else pass_cnt++;
        total_cnt++; if (bus.e_srcA !== F || bus.e_srcB !== F || bus.e_dstE !== F || bus.e_dstM !== F)
            $display("FAIL ins_err_idx got %0h %0h %0h %0h want f f f f", bus.e_srcA, bus.e_srcB, bus.e_dstE, bus.e_dstM);
        else pass_cnt++;
        set_decode(1'b1, 4'h9, 4'd0, 4'd0);
        step();
        total_cnt++; if (bus.e_srcA !== 4'd4 || bus.e_srcB !== 4'd4 || bus.e_dstE !== 4'd4 || bus.e_dstM !== F)
            $display("FAIL ret_idx got %0h %0h %0h %0h want 4 4 4 f", bus.e_srcA, bus.e_srcB, bus.e_dstE, bus.e_dstM);
        else pass_cnt++;
        total_cnt++; if (bus.e_valA !== 64'd254 || bus.e_ins_err !== 1'b0)
            $display("FAIL ret_valA got %0d err=%0b want 254 0", bus.e_valA, bus.e_ins_err);
        else pass_cnt++;
        set_decode(1'b1, 4'h5, 4'd3, 4'd1);
        step();
        total_cnt++; if (bus.e_srcA !== F || bus.e_srcB !== 4'd1 || bus.e_dstE !== F || bus.e_dstM !== 4'd3 || bus.e_valB !== 64'd555)
            $display("FAIL mrmov got srcA=%0h srcB=%0h dstE=%0h dstM=%0h valB=%0d want f 1 f 3 555", bus.e_srcA, bus.e_srcB, bus.e_dstE, bus.e_dstM, bus.e_valB);
        else pass_cnt++;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_bypass();
        test_pop_conflict();
        test_stall_bubble();
        test_ignored_writes();
        test_invalid_icode();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
